// File: rtl/mux_pkg.sv
// Shared constants for the stream mux/demux family.
// scale_demux_buf reads the destination codes, the buffer depth and the
// transfer-counter width from here.
package mux_pkg;

  // Destination codes carried on in_sel
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Entries held by each per-output buffer
  localparam int DEMUX_DEPTH = 2;

  // Width of the optional per-output transfer counters
  localparam int DEMUX_CNT_W = 16;

  // Occupancy value at which a per-output buffer is full
  function automatic logic [1:0] demux_full_occ();
    return 2'(DEMUX_DEPTH);
  endfunction

endpackage

// File: rtl/demux_fifo2.sv
// Two-entry FIFO with a registered head.
// rdata is driven directly from the head register, so it holds its value
// while the consumer stalls. After reset rdata reads 0.
// Handshake: a word is written when push is high and full is low; the head
// is removed when pop is high and valid is high. Either request is ignored
// when its qualifier is low, so the caller may drive them unqualified.
module demux_fifo2
  import mux_pkg::*;
#(
  parameter int size = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [size-1:0] wdata,
  output logic            full,
  input  logic            pop,
  output logic            valid,
  output logic [size-1:0] rdata
);

  logic [1:0]      r_cnt;
  logic [size-1:0] r_head;
  logic [size-1:0] r_tail;

  logic            w_push;
  logic            w_pop;

  assign full   = (r_cnt == demux_full_occ());
  assign valid  = (r_cnt != 2'd0);
  assign rdata  = r_head;

  assign w_push = push & ~full;
  assign w_pop  = pop & valid;

  // Occupancy and storage update; the head register always holds the oldest word
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= 2'd0;
      r_head <= '0;
      r_tail <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          // Write into the first free slot
          if (r_cnt == 2'd0) begin
            r_head <= wdata;
          end else begin
            r_tail <= wdata;
          end
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          // Advance the second word into the head; a lone head just goes stale
          if (r_cnt == 2'd2) begin
            r_head <= r_tail;
          end
          r_cnt <= r_cnt - 2'd1;
        end
        2'b11: begin
          // Only reachable with one entry: the new word replaces the departing head
          r_head <= wdata;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/scale_demux_buf.sv
// Registered 1-to-2 stream demultiplexer with a 2-entry buffer per output.
// Each input word goes to output a (in_sel = 0) or output b (in_sel = 1).
// A stalled sink only blocks words addressed to it.
// Optional feature: define SCALE_DEMUX_CNT_EN to add the a_cnt/b_cnt
// transfer counters, one increment per pop, wrapping at 16 bits.
//
// Handshake (all three streams): a transfer happens on a rising edge where
// valid and ready are both high. in_ready depends only on in_sel and the
// selected buffer's state, never on in_valid. An output's data is stable
// while its valid is high and ready is low.
module scale_demux_buf
  import mux_pkg::*;
#(
  parameter int size = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [size-1:0]        in_data,
  input  logic                   in_sel,
  output logic                   a_valid,
  input  logic                   a_ready,
  output logic [size-1:0]        a_data,
  output logic                   b_valid,
  input  logic                   b_ready,
  output logic [size-1:0]        b_data
`ifdef SCALE_DEMUX_CNT_EN
  ,
  output logic [DEMUX_CNT_W-1:0] a_cnt,
  output logic [DEMUX_CNT_W-1:0] b_cnt
`endif
);

  logic w_a_full;
  logic w_b_full;
  logic w_accept;
  logic w_push_a;
  logic w_push_b;
  logic w_pop_a;
  logic w_pop_b;

  // Ready reflects only the buffer the current word is addressed to
  assign in_ready = (in_sel == SEL_B) ? ~w_b_full : ~w_a_full;
  assign w_accept = in_valid & in_ready;
  assign w_push_a = w_accept & (in_sel == SEL_A);
  assign w_push_b = w_accept & (in_sel == SEL_B);
  assign w_pop_a  = a_valid & a_ready;
  assign w_pop_b  = b_valid & b_ready;

  demux_fifo2 #(
    .size (size)
  ) u_fifo_a (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push_a),
    .wdata (in_data),
    .full  (w_a_full),
    .pop   (w_pop_a),
    .valid (a_valid),
    .rdata (a_data)
  );

  demux_fifo2 #(
    .size (size)
  ) u_fifo_b (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push_b),
    .wdata (in_data),
    .full  (w_b_full),
    .pop   (w_pop_b),
    .valid (b_valid),
    .rdata (b_data)
  );

`ifdef SCALE_DEMUX_CNT_EN
  logic [DEMUX_CNT_W-1:0] r_a_cnt;
  logic [DEMUX_CNT_W-1:0] r_b_cnt;

  // Count completed output transfers; natural wrap at the counter width
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_cnt <= '0;
      r_b_cnt <= '0;
    end else begin
      if (w_pop_a) begin
        r_a_cnt <= r_a_cnt + 1'b1;
      end
      if (w_pop_b) begin
        r_b_cnt <= r_b_cnt + 1'b1;
      end
    end
  end

  assign a_cnt = r_a_cnt;
  assign b_cnt = r_b_cnt;
`endif

endmodule

// File: tb/tb_scale_demux_buf.sv
// Self-checking bench for scale_demux_buf: reset checks, a directed vector
// table, hand-written reset and stream sequences, and random traffic
// checked against a queue-based reference model.
module tb_scale_demux_buf;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_sel;
  logic         a_valid;
  logic         a_ready;
  logic [W-1:0] a_data;
  logic         b_valid;
  logic         b_ready;
  logic [W-1:0] b_data;
`ifdef SCALE_DEMUX_CNT_EN
  logic [15:0]  a_cnt;
  logic [15:0]  b_cnt;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  scale_demux_buf #(.size(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_data   (b_data)
`ifdef SCALE_DEMUX_CNT_EN
    ,
    .a_cnt    (a_cnt),
    .b_cnt    (b_cnt)
`endif
  );

  // ---------------- scoreboard / reference model ----------------
  // Each output is a queue of at most two words in arrival order.
  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];
  logic [15:0]  m_a_cnt;
  logic [15:0]  m_b_cnt;
  int           n_vec = 0;
  int           n_err = 0;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s vec=%0d got=%0h exp=%0h", name, n_vec, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a falling edge; inputs settle before the checks.
  task automatic drive(input logic v, input logic s, input logic [W-1:0] d,
                       input logic ar, input logic br);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    a_ready  = ar;
    b_ready  = br;
    #1;
  endtask

  task automatic check_model();
    logic exp_rdy;
    exp_rdy = in_sel ? (exp_b_q.size() < 2) : (exp_a_q.size() < 2);
    chk("in_ready", W'(in_ready), W'(exp_rdy));
    chk("a_valid", W'(a_valid), W'(exp_a_q.size() != 0));
    if (exp_a_q.size() != 0) chk("a_data", a_data, exp_a_q[0]);
    chk("b_valid", W'(b_valid), W'(exp_b_q.size() != 0));
    if (exp_b_q.size() != 0) chk("b_data", b_data, exp_b_q[0]);
`ifdef SCALE_DEMUX_CNT_EN
    chk("a_cnt", W'(a_cnt), W'(m_a_cnt));
    chk("b_cnt", W'(b_cnt), W'(m_b_cnt));
`endif
  endtask

  // Advance the model by the transfers implied by the current inputs,
  // then move to the next falling edge.
  task automatic tick();
    logic acc, pa, pb;
    if (rst) begin
      exp_a_q.delete();
      exp_b_q.delete();
      m_a_cnt = '0;
      m_b_cnt = '0;
    end else begin
      acc = in_valid && (in_sel ? (exp_b_q.size() < 2) : (exp_a_q.size() < 2));
      pa  = (exp_a_q.size() != 0) && a_ready;
      pb  = (exp_b_q.size() != 0) && b_ready;
      if (pa) begin
        void'(exp_a_q.pop_front());
        m_a_cnt = m_a_cnt + 16'd1;
      end
      if (pb) begin
        void'(exp_b_q.pop_front());
        m_b_cnt = m_b_cnt + 16'd1;
      end
      if (acc) begin
        if (in_sel) exp_b_q.push_back(in_data);
        else        exp_a_q.push_back(in_data);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic         v;
    logic         s;
    logic [W-1:0] d;
    logic         ar;
    logic         br;
    logic         e_rdy;
    logic         e_av;
    logic [W-1:0] e_ad;
    logic         e_bv;
    logic [W-1:0] e_bd;
  } vec_t;

  function automatic vec_t mk(logic v, logic s, logic [W-1:0] d, logic ar, logic br,
                              logic e_rdy, logic e_av, logic [W-1:0] e_ad,
                              logic e_bv, logic [W-1:0] e_bd);
    vec_t r;
    r.v = v; r.s = s; r.d = d; r.ar = ar; r.br = br;
    r.e_rdy = e_rdy; r.e_av = e_av; r.e_ad = e_ad; r.e_bv = e_bv; r.e_bd = e_bd;
    return r;
  endfunction

  vec_t tbl[16];

  initial begin
    // Expectations are the outputs seen while the row's inputs are applied.
    // Steering: 0x11 -> A, 0x22 -> B, 0x33 -> A, both sinks ready.
    tbl[0]  = mk(1, 0, 'h11, 1, 1,  1, 0, 'h00, 0, 'h00);
    tbl[1]  = mk(1, 1, 'h22, 1, 1,  1, 1, 'h11, 0, 'h00);
    tbl[2]  = mk(1, 0, 'h33, 1, 1,  1, 0, 'h00, 1, 'h22);
    tbl[3]  = mk(0, 0, 'h00, 1, 1,  1, 1, 'h33, 0, 'h00);
    tbl[4]  = mk(0, 0, 'h00, 1, 1,  1, 0, 'h00, 0, 'h00);
    // Backpressure isolation: A stalled, A3 stalls then is redirected to B.
    tbl[5]  = mk(1, 0, 'hA1, 0, 0,  1, 0, 'h00, 0, 'h00);
    tbl[6]  = mk(1, 0, 'hA2, 0, 0,  1, 1, 'hA1, 0, 'h00);
    tbl[7]  = mk(1, 1, 'hB1, 0, 0,  1, 1, 'hA1, 0, 'h00);
    tbl[8]  = mk(1, 0, 'hA3, 0, 0,  0, 1, 'hA1, 1, 'hB1);
    tbl[9]  = mk(1, 0, 'hA3, 0, 0,  0, 1, 'hA1, 1, 'hB1);
    tbl[10] = mk(1, 1, 'hA3, 0, 0,  1, 1, 'hA1, 1, 'hB1);
    tbl[11] = mk(0, 0, 'h00, 0, 1,  0, 1, 'hA1, 1, 'hB1);
    tbl[12] = mk(0, 0, 'h00, 0, 1,  0, 1, 'hA1, 1, 'hA3);
    tbl[13] = mk(0, 0, 'h00, 1, 1,  0, 1, 'hA1, 0, 'h00);
    tbl[14] = mk(0, 0, 'h00, 1, 1,  1, 1, 'hA2, 0, 'h00);
    tbl[15] = mk(0, 0, 'h00, 1, 1,  1, 0, 'h00, 0, 'h00);
  end

  // ---------------- test sequence ----------------
  initial begin
    exp_a_q.delete();
    exp_b_q.delete();
    m_a_cnt = '0;
    m_b_cnt = '0;

    // Reset held two cycles with in_valid high; nothing may be accepted.
    rst = 1'b1;
    drive(1, 0, 'hDEAD, 1, 1);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_a_valid", W'(a_valid), '0);
      chk("rst_b_valid", W'(b_valid), '0);
      chk("rst_a_data", a_data, '0);
      chk("rst_b_data", b_data, '0);
    end
    rst = 1'b0;
    drive(0, 0, '0, 1, 1);
    chk("post_rst_in_ready", W'(in_ready), W'(1'b1));
    check_model();
    tick();

    // Directed table
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].ar, tbl[i].br);
      chk("tbl_in_ready", W'(in_ready), W'(tbl[i].e_rdy));
      chk("tbl_a_valid", W'(a_valid), W'(tbl[i].e_av));
      if (tbl[i].e_av) chk("tbl_a_data", a_data, tbl[i].e_ad);
      chk("tbl_b_valid", W'(b_valid), W'(tbl[i].e_bv));
      if (tbl[i].e_bv) chk("tbl_b_data", b_data, tbl[i].e_bd);
      tick();
    end

    // Mid-operation reset: two words queued per output, then discarded.
    drive(1, 0, 'hC1, 0, 0); check_model(); tick();
    drive(1, 0, 'hC2, 0, 0); check_model(); tick();
    drive(1, 1, 'hD1, 0, 0); check_model(); tick();
    drive(1, 1, 'hD2, 0, 0); check_model(); tick();
    drive(0, 0, '0, 0, 0);   check_model();
    rst = 1'b1;
    drive(1, 0, 'hEE, 1, 1);
    tick();
    rst = 1'b0;
    drive(0, 0, '0, 1, 1);
    chk("mid_rst_a_valid", W'(a_valid), '0);
    chk("mid_rst_b_valid", W'(b_valid), '0);
    chk("mid_rst_a_data", a_data, '0);
    for (int i = 0; i < 4; i++) begin
      drive(0, $urandom_range(0, 1), '0, 1, 1);
      check_model();
      tick();
    end

    // Streaming: 100 back-to-back words to A with A always ready.
    for (int i = 0; i < 100; i++) begin
      drive(1, 0, $urandom, 1, 1'($urandom_range(0, 1)));
      chk("stream_in_ready", W'(in_ready), W'(1'b1));
      check_model();
      tick();
    end
    drive(0, 0, '0, 1, 1); check_model(); tick();

    // Random traffic with random backpressure on both sinks.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
      check_model();
      tick();
    end

`ifdef SCALE_DEMUX_CNT_EN
    // Counter wrap: preload a_cnt near the top, pop three words from A.
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, '0, 1, 1);
      tick();
    end
    force dut.r_a_cnt = 16'hFFFE;
    m_a_cnt = 16'hFFFE;
    #1;
    release dut.r_a_cnt;
    drive(1, 0, 'h51, 1, 0); check_model(); tick();
    drive(1, 0, 'h52, 1, 0); check_model(); tick();
    drive(1, 0, 'h53, 1, 0); check_model(); tick();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, '0, 1, 0); check_model(); tick();
    end
    chk("cnt_wrap_a", W'(a_cnt), W'(16'h0001));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
